// File: rtl/video_mode_sched_pkg.sv
// Shared constants for the frame-synchronous video mode scheduler.
// Mode encodings as seen on the port decoder, plus the commit FSM state set.
package video_mode_sched_pkg;

  localparam logic [2:0] MODE_PENT      = 3'b011;
  localparam logic [2:0] MODE_ATM_EGA   = 3'b000;
  localparam logic [2:0] MODE_ATM_HIRES = 3'b010;
  localparam logic [2:0] MODE_ATM_TEXT  = 3'b110;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PEND   = 2'd1,
    SETTLE = 2'd2
  } state_t;

  // Pentagon is the only mode using the 192-line vertical window.
  function automatic logic is_pent(input logic [2:0] m);
    return (m == MODE_PENT);
  endfunction

endpackage

// File: rtl/video_mode_sched_int_shaper.sv
// Z80 INT pulse shaper: int_start drives int_n low for INT_LEN clocks,
// cut short by int_ack; a new int_start always restarts the pulse.
module video_mode_sched_int_shaper #(
  parameter logic [8:0] INT_LEN = 9'd256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic int_start,
  input  logic int_ack,
  output logic int_n
);

  logic [8:0] cnt;

  // cnt holds the clocks still to go after the current one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_n <= 1'b1;
      cnt   <= 9'd0;
    end else if (int_start) begin
      int_n <= 1'b0;
      cnt   <= INT_LEN - 9'd1;
    end else if (!int_n) begin
      if (int_ack) begin
        int_n <= 1'b1;
        cnt   <= 9'd0;
      end else if (cnt == 9'd0) begin
        int_n <= 1'b1;
      end else begin
        cnt <= cnt - 9'd1;
      end
    end
  end

endmodule

// File: rtl/video_mode_sched.sv
// Shadows CPU mode writes and commits them on the vblank rising edge, then
// blanks for SETTLE_LINES lines; also shapes Z80 INT and counts frames.
module video_mode_sched
  import video_mode_sched_pkg::*;
#(
  parameter logic [2:0] RESET_MODE   = 3'b011,
  parameter logic [3:0] SETTLE_LINES = 4'd4,
  parameter logic [8:0] INT_LEN      = 9'd256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hsync_start,
  input  logic       vblank,
  input  logic       int_start,
  input  logic       wr_req,
  input  logic [2:0] wr_mode,
  input  logic       int_ack,
  output logic [2:0] mode,
  output logic       mode_atm_n_pent,
  output logic       pending,
  output logic       force_blank,
  output logic       int_n,
  output logic [7:0] frame_cnt
);

  state_t     state, state_nx;
  logic [2:0] shadow, shadow_nx, mode_nx;
  logic       pending_nx, blank_nx;
  logic [3:0] settle_cnt, settle_nx;
  logic       vblank_d;
  logic       vb_rise;

  assign vb_rise = vblank & ~vblank_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      shadow          <= RESET_MODE;
      pending         <= 1'b0;
      mode            <= RESET_MODE;
      mode_atm_n_pent <= is_pent(RESET_MODE);
      force_blank     <= 1'b0;
      settle_cnt      <= 4'd0;
      vblank_d        <= 1'b0;
      frame_cnt       <= 8'd0;
    end else begin
      state           <= state_nx;
      shadow          <= shadow_nx;
      pending         <= pending_nx;
      mode            <= mode_nx;
      mode_atm_n_pent <= is_pent(mode_nx);
      force_blank     <= blank_nx;
      settle_cnt      <= settle_nx;
      vblank_d        <= vblank;
      if (int_start) frame_cnt <= frame_cnt + 8'd1;
    end
  end

  always_comb begin
    state_nx   = state;
    shadow_nx  = shadow;
    pending_nx = pending;
    mode_nx    = mode;
    blank_nx   = force_blank;
    settle_nx  = settle_cnt;
    case (state)
      IDLE: begin
        if (wr_req) begin
          shadow_nx  = wr_mode;
          pending_nx = 1'b1;
          state_nx   = PEND;
        end
      end
      PEND: begin
        if (wr_req) shadow_nx = wr_mode;
        // A write landing on the vblank edge bypasses straight into the commit.
        if (vb_rise) begin
          mode_nx    = wr_req ? wr_mode : shadow;
          pending_nx = 1'b0;
          blank_nx   = 1'b1;
          settle_nx  = SETTLE_LINES;
          state_nx   = SETTLE;
        end
      end
      SETTLE: begin
        if (wr_req) begin
          shadow_nx  = wr_mode;
          pending_nx = 1'b1;
        end
        if (hsync_start) begin
          settle_nx = settle_cnt - 4'd1;
          if (settle_cnt == 4'd1) begin
            blank_nx = 1'b0;
            state_nx = (pending || wr_req) ? PEND : IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  video_mode_sched_int_shaper #(
    .INT_LEN(INT_LEN)
  ) u_int_shaper (
    .clk      (clk),
    .rst_n    (rst_n),
    .int_start(int_start),
    .int_ack  (int_ack),
    .int_n    (int_n)
  );

endmodule

// File: tb/tb_video_mode_sched.sv
// Randomised frame-timing bench for video_mode_sched with an event-level
// reference model feeding an expected-output queue drained by a monitor.
module tb_video_mode_sched;
  import video_mode_sched_pkg::*;

  localparam int LINE_CLKS   = 8;
  localparam int FRAME_LINES = 40;
  localparam int FRAME_CLKS  = LINE_CLKS * FRAME_LINES;
  localparam int VB_LINE     = 32;
  localparam int INT_LINE    = 33;
  localparam int SETTLE_N    = 4;
  localparam int INT_CYC     = 256;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       hsync_start = 1'b0;
  logic       vblank = 1'b0;
  logic       int_start = 1'b0;
  logic       wr_req = 1'b0;
  logic [2:0] wr_mode = 3'd0;
  logic       int_ack = 1'b0;
  logic [2:0] mode;
  logic       mode_atm_n_pent;
  logic       pending;
  logic       force_blank;
  logic       int_n;
  logic [7:0] frame_cnt;

  video_mode_sched #(
    .RESET_MODE  (3'b011),
    .SETTLE_LINES(4'd4),
    .INT_LEN     (9'd256)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .hsync_start    (hsync_start),
    .vblank         (vblank),
    .int_start      (int_start),
    .wr_req         (wr_req),
    .wr_mode        (wr_mode),
    .int_ack        (int_ack),
    .mode           (mode),
    .mode_atm_n_pent(mode_atm_n_pent),
    .pending        (pending),
    .force_blank    (force_blank),
    .int_n          (int_n),
    .frame_cnt      (frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] mode;
    logic       atm;
    logic       pending;
    logic       fb;
    logic       int_n;
    logic [7:0] frame;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   pos = 0;

  // Reference model: applied mode, last written mode, whether a write is
  // outstanding, blanking lines still to go, INT low clocks still to go.
  logic [2:0] m_mode, m_shadow;
  bit         m_pend, m_prev_vb;
  int         m_settle, m_int_left, m_frames;

  task automatic model_reset();
    m_mode = 3'b011; m_shadow = 3'b011; m_pend = 0; m_prev_vb = 0;
    m_settle = 0; m_int_left = 0; m_frames = 0;
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.mode    = m_mode;
    e.atm     = (m_mode == 3'b011);
    e.pending = m_pend;
    e.fb      = (m_settle > 0);
    e.int_n   = (m_int_left == 0);
    e.frame   = 8'(m_frames);
    return e;
  endfunction

  task automatic model_step();
    bit rise;
    rise = vblank && !m_prev_vb;
    m_prev_vb = vblank;
    if (m_settle > 0) begin
      if (wr_req) begin m_shadow = wr_mode; m_pend = 1; end
      if (hsync_start) m_settle = m_settle - 1;
    end else if (m_pend && rise) begin
      m_mode   = wr_req ? wr_mode : m_shadow;
      m_pend   = 0;
      m_settle = SETTLE_N;
    end else if (wr_req) begin
      m_shadow = wr_mode; m_pend = 1;
    end
    if (int_start) begin
      m_int_left = INT_CYC;
      m_frames   = m_frames + 1;
    end else if (m_int_left > 0) begin
      m_int_left = int_ack ? 0 : m_int_left - 1;
    end
  endtask

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_mode"}, int'(mode), 3);
    check({tag, "_atm"}, int'(mode_atm_n_pent), 1);
    check({tag, "_pending"}, int'(pending), 0);
    check({tag, "_force_blank"}, int'(force_blank), 0);
    check({tag, "_int_n"}, int'(int_n), 1);
    check({tag, "_frame_cnt"}, int'(frame_cnt), 0);
  endtask

  // Drive one clock's worth of frame timing plus random CPU/Z80 activity,
  // called at the falling edge so the next rising edge samples it.
  task automatic cycle(input int wr_permille, input bit ack_en);
    int p, line;
    p    = pos % FRAME_CLKS;
    line = p / LINE_CLKS;
    hsync_start = (p % LINE_CLKS == 0);
    vblank      = (line >= VB_LINE);
    int_start   = (p == INT_LINE * LINE_CLKS) || (ack_en && $urandom_range(999) == 0);
    wr_req      = (int'($urandom_range(999)) < wr_permille);
    if (wr_permille > 0 && p == VB_LINE * LINE_CLKS) wr_req = ($urandom_range(1) == 1);
    wr_mode     = 3'($urandom_range(7));
    int_ack     = 1'b0;
    if (ack_en) begin
      int_ack = ($urandom_range(249) == 0);
      if (p == INT_LINE * LINE_CLKS + 10 && $urandom_range(2) == 0) int_ack = 1'b1;
      if (p == INT_LINE * LINE_CLKS && $urandom_range(3) == 0) int_ack = 1'b1;
    end
    model_step();
    exp_q.push_back(model_out());
    pos++;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("mode", int'(mode), int'(e.mode));
        check("mode_atm_n_pent", int'(mode_atm_n_pent), int'(e.atm));
        check("pending", int'(pending), int'(e.pending));
        check("force_blank", int'(force_blank), int'(e.fb));
        check("int_n", int'(int_n), int'(e.int_n));
        check("frame_cnt", int'(frame_cnt), int'(e.frame));
      end
    end
  end

  initial begin : stimulus
    bit hit;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_values("reset_init");
    rst_n = 1'b1;

    // Quiet frames: no writes, no acks.
    for (int i = 0; i < 3 * FRAME_CLKS; i++) begin
      if (i > 0) @(negedge clk);
      cycle(0, 1'b0);
    end
    @(posedge clk);
    #2;
    check("quiet_frame_cnt", int'(frame_cnt), 3);
    check("quiet_mode", int'(mode), 3);

    // Busy frames: random writes, writes on the vblank edge, random acks.
    for (int i = 0; i < 30 * FRAME_CLKS; i++) begin
      @(negedge clk);
      cycle(8, 1'b1);
    end

    // Reset asserted while blanking with a write outstanding.
    hit = 0;
    for (int i = 0; i < 20 * FRAME_CLKS && !hit; i++) begin
      @(negedge clk);
      if (m_settle > 0 && m_pend) begin
        hit = 1;
        rst_n = 1'b0;
        #1;
        check_reset_values("reset_async");
        model_reset();
        exp_q.push_back(model_out());
        @(negedge clk);
        exp_q.push_back(model_out());
        @(negedge clk);
        rst_n = 1'b1;
        cycle(0, 1'b0);
      end else begin
        cycle(25, 1'b1);
      end
    end
    check("reset_in_settle_reached", int'(hit), 1);

    // After the reset the discarded write must never commit.
    for (int i = 0; i < 2 * FRAME_CLKS; i++) begin
      @(negedge clk);
      cycle(0, 1'b0);
    end
    @(posedge clk);
    #2;
    check("post_reset_mode", int'(mode), 3);
    check("post_reset_pending", int'(pending), 0);

    repeat (2) @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
